// File: rtl/hsi_m_rx_nch.sv
// HSI master receive controller: N_CH redundant serial lines, UART-style framing,
// parity/stop checks, show-ahead output FIFO with ready/ack pop.

module hsi_m_rx_sync (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

module hsi_m_rx_nch #(
  parameter int N_CH       = 2,
  parameter int DATA_W     = 8,
  parameter int OVS        = 8,
  parameter int PARITY     = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int SRC_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clk_en,
  input  logic              sdreq_en,
  input  logic [SRC_W-1:0]  dat_src,
  input  logic [N_CH-1:0]   dat,
  output logic [DATA_W-1:0] q,
  output logic              q_rdy,
  input  logic              q_ack,
  output logic [LVL_W-1:0]  q_lvl,
  output logic              par_err,
  output logic              frm_err,
  output logic              ovf,
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} st_t;
  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic [N_CH-1:0]   s;
  logic              sel, armed, perr, abort, src_chg;
  logic [SRC_W-1:0]  src_q;
  st_t               st;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bcnt;
  logic [DATA_W-1:0] sh;
  wr_t               wr;

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    hsi_m_rx_sync u_sync (.clk(clk), .n_rst(n_rst), .d(dat[i]), .q(s[i]));
  end

  // unmatched (out-of-range) selection falls through to idle level
  always_comb begin
    sel = 1'b1;
    for (int i = 0; i < N_CH; i++)
      if (dat_src == SRC_W'(i)) sel = s[i];
  end

  assign src_chg = (dat_src != src_q);
  assign abort   = (st != IDLE) && (src_chg || !sdreq_en);
  assign busy    = (st != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      src_q <= '0;
      armed <= 1'b0;
    end else begin
      src_q <= dat_src;
      if (src_chg || !sdreq_en) armed <= 1'b0;
      else if (clk_en) begin
        if (st == STOP && cnt == CW'(OVS - 1)) armed <= sel;
        else if (sel) armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st      <= IDLE;
      cnt     <= '0;
      bcnt    <= '0;
      sh      <= '0;
      perr    <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      par_err <= 1'b0;
      frm_err <= 1'b0;
      if (abort) st <= IDLE;
      else if (clk_en) begin
        unique case (st)
          IDLE: if (armed && !sel) begin
            st  <= START;
            cnt <= '0;
          end
          START: if (cnt == CW'(OVS / 2 - 1)) begin
            cnt  <= '0;
            bcnt <= '0;
            perr <= 1'b0;
            if (sel) begin
              frm_err <= 1'b1;
              st      <= IDLE;
            end else st <= DATA;
          end else cnt <= cnt + 1'b1;
          DATA: if (cnt == CW'(OVS - 1)) begin
            cnt <= '0;
            sh  <= DATA_W'({sel, sh} >> 1);
            if (bcnt == BW'(DATA_W - 1)) st <= (PARITY != 0) ? PAR : STOP;
            else bcnt <= bcnt + 1'b1;
          end else cnt <= cnt + 1'b1;
          PAR: if (cnt == CW'(OVS - 1)) begin
            cnt  <= '0;
            perr <= ~((^sh) ^ sel);
            st   <= STOP;
          end else cnt <= cnt + 1'b1;
          STOP: if (cnt == CW'(OVS - 1)) begin
            cnt <= '0;
            st  <= IDLE;
            if (!sel) frm_err <= 1'b1;
            else if (perr) par_err <= 1'b1;
          end else cnt <= cnt + 1'b1;
          default: st <= IDLE;
        endcase
      end
    end
  end

  // the word enters the FIFO on the stop-sample edge itself
  assign wr.vld = clk_en && (st == STOP) && (cnt == CW'(OVS - 1)) && sel && !perr && !abort;
  assign wr.d   = sh;

  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW:0] wp, rp;
  logic        pop, full, we;

  assign q_lvl = LVL_W'(wp - rp);
  assign q_rdy = (wp != rp);
  assign full  = (q_lvl == LVL_W'(FIFO_DEPTH));
  assign pop   = q_ack && q_rdy;
  assign we    = wr.vld && (!full || pop);
  assign q     = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem <= '0;
      wp  <= '0;
      rp  <= '0;
      ovf <= 1'b0;
    end else begin
      ovf <= wr.vld && full && !pop;
      if (we) begin
        mem[wp[AW-1:0]] <= wr.d;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: tb/tb_hsi_m_rx_nch.sv
// Bench for hsi_m_rx_nch: frame-level model (expected word queue + per-frame outcome
// events) checked against the DUT every cycle, plus literal spot checks.

module tb_hsi_m_rx_nch;
  localparam int N_CH = 2, DATA_W = 8, OVS = 8, PARITY = 1, FIFO_DEPTH = 4;
  // line edge -> 2-FF sync -> start detect, then mid-bit samples up to the stop bit
  localparam int LAT  = 3 + OVS / 2 + OVS * (DATA_W + PARITY + 1);
  localparam int GLAT = 3 + OVS / 2;
  localparam int K_NONE = -1, K_PUSH = 0, K_PAR = 1, K_FRM = 2;

  logic              clk = 0, n_rst = 0, clk_en = 1, sdreq_en = 1, q_ack = 0;
  logic [0:0]        dat_src = 1;
  logic [N_CH-1:0]   dat = '1;
  logic [DATA_W-1:0] q;
  logic              q_rdy, par_err, frm_err, ovf, busy;
  logic [2:0]        q_lvl;

  hsi_m_rx_nch #(.N_CH(N_CH), .DATA_W(DATA_W), .OVS(OVS), .PARITY(PARITY),
                 .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .clk_en(clk_en), .sdreq_en(sdreq_en), .dat_src(dat_src),
    .dat(dat), .q(q), .q_rdy(q_rdy), .q_ack(q_ack), .q_lvl(q_lvl), .par_err(par_err),
    .frm_err(frm_err), .ovf(ovf), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int c; int k; logic [7:0] d; } ev_t;
  ev_t         evq[$];
  logic [7:0]  mq[$];
  int          cyc = 0, nchk = 0, nerr = 0, ovf_cnt = 0;
  logic        pend_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!n_rst) begin
      mq.delete();
      evq.delete();
      pend_pop = 0;
    end else begin
      logic e_par, e_frm, e_ovf;
      ev_t  ev;
      e_par = 0; e_frm = 0; e_ovf = 0;
      if (pend_pop) void'(mq.pop_front());
      while (evq.size() > 0 && evq[0].c == cyc) begin
        ev = evq.pop_front();
        case (ev.k)
          K_PUSH: if (mq.size() == FIFO_DEPTH) e_ovf = 1; else mq.push_back(ev.d);
          K_PAR:  e_par = 1;
          default: e_frm = 1;
        endcase
      end
      chk("q_rdy", q_rdy, mq.size() > 0);
      chk("q_lvl", q_lvl, mq.size());
      if (mq.size() > 0) chk("q", q, mq[0]);
      chk("par_err", par_err, e_par);
      chk("frm_err", frm_err, e_frm);
      chk("ovf", ovf, e_ovf);
      if (ovf) ovf_cnt++;
      pend_pop = q_ack && (mq.size() > 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int ln, input logic [7:0] d, input logic bad_par,
                            input logic stop_b, input int kind);
    logic [10:0] bits;
    int e0;
    @(posedge clk); #1;
    e0 = cyc;
    bits = {stop_b, bad_par ? ^d : ~^d, d, 1'b0};
    if (kind != K_NONE) evq.push_back('{e0 + LAT, kind, d});
    for (int i = 0; i < 11; i++) begin
      dat[ln] = bits[i];
      idle(OVS);
    end
  endtask

  task automatic glitch(input int ln);
    int e0;
    @(posedge clk); #1;
    e0 = cyc;
    evq.push_back('{e0 + GLAT, K_FRM, 8'h00});
    dat[ln] = 0;
    idle(2);
    dat[ln] = 1;
  endtask

  task automatic pop(input logic [7:0] exp);
    chk("pop_rdy", q_rdy, 1);
    chk("pop_q", q, exp);
    q_ack = 1;
    idle(1);
    q_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk("rst_q_rdy", q_rdy, 0);
    chk("rst_q_lvl", q_lvl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {par_err, frm_err, ovf}, 0);
    chk("rst_q", q, 0);
    n_rst = 1;
    idle(10);

    // basic frame on line 1, literal head and latency
    send_frame(1, 8'hA5, 0, 1, K_PUSH);
    chk("a5_q", q, 8'hA5);
    chk("a5_lvl", q_lvl, 1);
    pop(8'hA5);
    idle(5);

    // wrong parity dropped, then the same word with good parity
    send_frame(1, 8'h3C, 1, 1, K_PAR);
    chk("par_lvl", q_lvl, 0);
    idle(5);
    send_frame(1, 8'h3C, 0, 1, K_PUSH);
    pop(8'h3C);
    idle(5);

    // stop bit 0, then the line held low must not start a new frame
    send_frame(1, 8'h5A, 0, 0, K_FRM);
    idle(20);
    chk("hold0_busy", busy, 0);
    idle(20);
    dat[1] = 1;
    idle(10);

    glitch(1);
    idle(10);
    chk("glitch_busy", busy, 0);

    // overflow on the fifth word with no acks
    for (int i = 0; i < 5; i++) begin
      send_frame(1, 8'h11 + 8'(i), 0, 1, K_PUSH);
      idle(3);
    end
    chk("ovf_cnt", ovf_cnt, 1);
    chk("ovf_lvl", q_lvl, 4);
    for (int i = 0; i < 4; i++) pop(8'h11 + 8'(i));
    idle(5);

    // fifth push coincides with a pop: no overflow, order preserved
    for (int i = 0; i < 4; i++) begin
      send_frame(1, 8'h21 + 8'(i), 0, 1, K_PUSH);
      idle(3);
    end
    fork
      send_frame(1, 8'h25, 0, 1, K_PUSH);
      begin idle(LAT); q_ack = 1; idle(1); q_ack = 0; end
    join
    chk("ack_lvl", q_lvl, 4);
    chk("ack_ovf_cnt", ovf_cnt, 1);
    for (int i = 0; i < 4; i++) pop(8'h22 + 8'(i));
    idle(5);

    // line switch mid-data aborts silently; next frame on new line is good
    fork
      send_frame(1, 8'h66, 0, 1, K_NONE);
      begin
        idle(30);
        chk("sw_busy_before", busy, 1);
        dat_src = 0;
        idle(2);
        chk("sw_busy_after", busy, 0);
      end
    join
    idle(5);
    send_frame(0, 8'h99, 0, 1, K_PUSH);
    pop(8'h99);
    idle(5);

    // receive disable aborts a frame but keeps stored words
    send_frame(0, 8'h42, 0, 1, K_PUSH);
    fork
      send_frame(0, 8'h77, 0, 1, K_NONE);
      begin idle(30); sdreq_en = 0; idle(2); chk("dis_busy", busy, 0); end
    join
    chk("dis_lvl", q_lvl, 1);
    sdreq_en = 1;
    idle(10);
    pop(8'h42);
    idle(5);

    // reset mid-frame empties the FIFO and drops the frame
    send_frame(0, 8'h0F, 0, 1, K_PUSH);
    fork
      send_frame(0, 8'hFF, 0, 1, K_NONE);
      begin idle(40); n_rst = 0; idle(1); n_rst = 1; end
    join
    chk("rst2_lvl", q_lvl, 0);
    chk("rst2_busy", busy, 0);
    idle(5);
    send_frame(0, 8'hC3, 0, 1, K_PUSH);
    pop(8'hC3);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
